// File: rtl/lut_serial_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lut_serial_writer_pkg
//  Description : Shared types and helper functions for the serial LUT writer.
//                Contents: the writer state encoding, the table-size function
//                and a ceil(log2) helper used to size the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package lut_serial_writer_pkg;

    // PRERST is only reachable when LUT_SERIAL_WRITER_TGT_RESET_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRERST = 3'd1,
        SETUP  = 3'd2,
        HIGH   = 3'd3,
        LOW    = 3'd4,
        TAIL   = 3'd5
    } state_t;

    // Total number of bits in a table image: 2**in_width entries of out_width.
    function automatic int table_bits(input int in_width, input int out_width);
        return (1 << in_width) * out_width;
    endfunction

    // Bits needed to hold values 0..value-1; never less than one.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_writer_half_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lut_writer_half_timer
//  Description : Half-period timer for the serial LUT writer. A down-counter
//                that reloads to CLK_DIV-1 on i_load and flags o_expire while
//                it sits at zero, so each state lasts exactly CLK_DIV cycles
//                when the caller reloads on every expiry.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                i_load   - reload the counter to CLK_DIV-1
//                o_expire - counter is at zero (last cycle of the period)
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_writer_half_timer #(
    parameter int WIDTH   = 1,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_expire
);

    localparam logic [WIDTH-1:0] C_RELOAD = WIDTH'(CLK_DIV - 1);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= C_RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lut_serial_writer.sv
`default_nettype none
// ============================================================================
//  Module      : lut_serial_writer
//  Description : Host-side programmer for a serially loaded LUT. Captures a
//                whole table image on an accepted start and shifts it out
//                MSB-first on sdo with a generated sclk and active-low cs_n,
//                leaving the target shift register equal to table_in.
//  Ports       : clk       - system clock, rising edge
//                rst       - synchronous active-high reset (aborts a load)
//                start     - load request, sampled only while busy=0
//                table_in  - table image, entry i at [(i+1)*OUT_WIDTH-1 -: OUT_WIDTH]
//                busy      - load in progress
//                done      - one-cycle completion pulse
//                sdo       - serial data to target d
//                sclk      - serial clock to target clk
//                cs_n      - active-low chip select to target
//                tgt_rst_n - active-low target reset (optional, see below)
//  Options     : LUT_SERIAL_WRITER_TGT_RESET_EN adds tgt_rst_n and a PRERST
//                phase that clears the target before each load; an abort by
//                rst also pulses tgt_rst_n low for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_serial_writer
    import lut_serial_writer_pkg::*;
#(
    parameter  int IN_WIDTH   = 3,
    parameter  int OUT_WIDTH  = 4,
    parameter  int CLK_DIV    = 2,
    localparam int TABLE_BITS = table_bits(IN_WIDTH, OUT_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TABLE_BITS-1:0] table_in,
    output logic                  busy,
    output logic                  done,
    output logic                  sdo,
    output logic                  sclk,
    output logic                  cs_n
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
    ,
    output logic                  tgt_rst_n
`endif
);

    localparam int CW = clog2(TABLE_BITS + 1);
    localparam int TW = clog2(CLK_DIV);

    state_t                r_state;
    state_t                w_state_next;
    logic [TABLE_BITS-1:0] r_shadow;
    logic [TABLE_BITS-1:0] w_shadow_next;
    logic [CW-1:0]         r_bit_cnt;
    logic [CW-1:0]         w_bit_cnt_next;
    logic                  w_done_next;
    logic                  w_expire;
    logic                  w_timer_load;

    // Held loaded while idle so every new state starts a full half-period;
    // afterwards each expiry coincides with a state change and reloads it.
    assign w_timer_load = (r_state == IDLE) || w_expire;

    lut_writer_half_timer #(
        .WIDTH   (TW),
        .CLK_DIV (CLK_DIV)
    ) u_half_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_timer_load),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shadow_next  = r_shadow;
        w_bit_cnt_next = r_bit_cnt;
        w_done_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shadow_next  = table_in;
                    w_bit_cnt_next = CW'(TABLE_BITS);
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
                    w_state_next   = PRERST;
`else
                    w_state_next   = SETUP;
`endif
                end
            end
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
            PRERST: begin
                if (w_expire) w_state_next = SETUP;
            end
`endif
            SETUP: begin
                if (w_expire) w_state_next = HIGH;
            end
            HIGH: begin
                if (w_expire) begin
                    w_bit_cnt_next = r_bit_cnt - 1'b1;
                    // The final bit is not shifted away: sdo keeps it through TAIL.
                    if (r_bit_cnt == CW'(1)) begin
                        w_state_next = TAIL;
                    end else begin
                        w_shadow_next = {r_shadow[TABLE_BITS-2:0], 1'b0};
                        w_state_next  = LOW;
                    end
                end
            end
            LOW: begin
                if (w_expire) w_state_next = HIGH;
            end
            TAIL: begin
                if (w_expire) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so none of
    // them has a combinational path from an input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_bit_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sdo       <= 1'b0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
            // An abort wipes the partially loaded target for one cycle.
            tgt_rst_n <= (r_state == IDLE);
`endif
        end else begin
            r_state   <= w_state_next;
            r_shadow  <= w_shadow_next;
            r_bit_cnt <= w_bit_cnt_next;
            busy      <= (w_state_next != IDLE);
            done      <= w_done_next;
            sclk      <= (w_state_next == HIGH);
            cs_n      <= !(w_state_next inside {SETUP, HIGH, LOW, TAIL});
            if (w_state_next == SETUP || w_state_next == LOW) begin
                sdo <= w_shadow_next[TABLE_BITS-1];
            end
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
            tgt_rst_n <= (w_state_next != PRERST);
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lut_serial_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_serial_writer
//  Description : Self-checking bench for lut_serial_writer. One instance at
//                default parameters, one with CLK_DIV=1. Behavioural target
//                shift registers capture sdo on every sclk rise.
//  Options     : LUT_SERIAL_WRITER_TGT_RESET_EN (must match the RTL build)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_serial_writer;

`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT2 = 131 + 2 * EXTRA;
    localparam int LAT1 = 66 + EXTRA;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start1;
    logic [31:0] table_in, table_in1;
    logic        busy, done, sdo, sclk, cs_n;
    logic        busy1, done1, sdo1, sclk1, cs_n1;
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
    logic        tgt_rst_n, tgt_rst_n1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lut_serial_writer #(.IN_WIDTH(3), .OUT_WIDTH(4), .CLK_DIV(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .table_in(table_in),
        .busy(busy), .done(done), .sdo(sdo), .sclk(sclk), .cs_n(cs_n)
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
        , .tgt_rst_n(tgt_rst_n)
`endif
    );

    lut_serial_writer #(.IN_WIDTH(3), .OUT_WIDTH(4), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .table_in(table_in1),
        .busy(busy1), .done(done1), .sdo(sdo1), .sclk(sclk1), .cs_n(cs_n1)
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
        , .tgt_rst_n(tgt_rst_n1)
`endif
    );

    // Free-running cycle number; changes only on rising edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Target model and protocol watch for the CLK_DIV=2 instance.
    logic        prev_sclk = 1'b0, prev_sdo = 1'b0;
    int          stab = 0, rises = 0, dones = 0;
    int          viol_sdo = 0, viol_cs = 0, viol_setup = 0;
    logic [31:0] tgt = '0;
    always @(negedge clk) begin
        if (sdo !== prev_sdo) begin
            if (sclk) viol_sdo <= viol_sdo + 1;
            stab <= 1;
        end else begin
            stab <= stab + 1;
        end
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rises <= rises + 1;
            tgt   <= {tgt[30:0], sdo};
            if (cs_n !== 1'b0) viol_cs <= viol_cs + 1;
            if (sdo !== prev_sdo || stab < 2) viol_setup <= viol_setup + 1;
        end
        if (done === 1'b1) dones <= dones + 1;
        prev_sclk <= sclk;
        prev_sdo  <= sdo;
    end

    // Target model for the CLK_DIV=1 instance.
    logic        prev_sclk1 = 1'b0;
    int          rises1 = 0, dones1 = 0, viol1 = 0;
    logic [31:0] tgt1 = '0;
    always @(negedge clk) begin
        if (sclk1 === 1'b1 && prev_sclk1 === 1'b0) begin
            rises1 <= rises1 + 1;
            tgt1   <= {tgt1[30:0], sdo1};
            if (cs_n1 !== 1'b0) viol1 <= viol1 + 1;
        end
        if (done1 === 1'b1) dones1 <= dones1 + 1;
        prev_sclk1 <= sclk1;
    end

`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
    int trst_run = 0, trst_last = 0, viol_trst = 0;
    always @(negedge clk) begin
        if (tgt_rst_n === 1'b0) begin
            trst_run <= trst_run + 1;
            if (cs_n !== 1'b1) viol_trst <= viol_trst + 1;
        end else if (trst_run != 0) begin
            trst_last <= trst_run;
            trst_run  <= 0;
        end
    end
`endif

    task automatic do_start(input logic [31:0] tbl, output int acc);
        @(posedge clk); #1;
        start    = 1'b1;
        table_in = tbl;
        acc      = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 1'b0;
        dc = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (sdo  !== 1'b0) begin bad++; $display("FAIL reset_sdo: got %b want 0", sdo); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
        total++; if (tgt_rst_n !== 1'b1) begin bad++; $display("FAIL reset_tgt_rst_n: got %b want 1", tgt_rst_n); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int acc, dc, r0, d0;
        bit ok;
        r0 = rises; d0 = dones;
        do_start(32'hFEDCBA98, acc);
        wait_done(dc, ok);
        @(posedge clk); #1;
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
        total++; if (dc - acc != LAT2) begin bad++; $display("FAIL basic_latency: got %0d want %0d", dc - acc, LAT2); end
        total++; if (rises - r0 != 32) begin bad++; $display("FAIL basic_rises: got %0d want 32", rises - r0); end
        total++; if (tgt !== 32'hFEDCBA98) begin bad++; $display("FAIL basic_target: got %h want fedcba98", tgt); end
        total++; if (dones - d0 != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", dones - d0); end
        total++; if (viol_sdo + viol_cs + viol_setup != 0) begin bad++;
            $display("FAIL basic_protocol: got sdo=%0d cs=%0d setup=%0d violations want 0", viol_sdo, viol_cs, viol_setup); end
        total++; if (cs_n !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL basic_idle: got cs_n=%b busy=%b want 1 0", cs_n, busy); end
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
        total++; if (trst_last != 2 || viol_trst != 0) begin bad++;
            $display("FAIL basic_prerst: got low=%0d viol=%0d want 2 0", trst_last, viol_trst); end
`endif
    endtask

    task automatic test_clkdiv1;
        int acc, dc, r0, d0;
        bit ok;
        r0 = rises1; d0 = dones1; ok = 1'b0; dc = 0;
        @(posedge clk); #1;
        start1 = 1'b1; table_in1 = 32'h00000001; acc = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin dc = cyc; ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        total++; if (!ok) begin bad++; $display("FAIL div1_timeout: got no done want done"); end
        total++; if (dc - acc != LAT1) begin bad++; $display("FAIL div1_latency: got %0d want %0d", dc - acc, LAT1); end
        total++; if (rises1 - r0 != 32) begin bad++; $display("FAIL div1_rises: got %0d want 32", rises1 - r0); end
        total++; if (tgt1 !== 32'h00000001) begin bad++; $display("FAIL div1_target: got %h want 00000001", tgt1); end
        total++; if (dones1 - d0 != 1) begin bad++; $display("FAIL div1_done_count: got %0d want 1", dones1 - d0); end
        total++; if (busy1 !== 1'b0 || viol1 != 0) begin bad++;
            $display("FAIL div1_idle: got busy=%b viol=%0d want 0 0", busy1, viol1); end
    endtask

    task automatic test_ignore_start;
        int acc, dc, d0, gaps;
        bit ok;
        d0 = dones; gaps = 0; ok = 1'b0; dc = 0;
        do_start(32'h12345678, acc);
        table_in = 32'hFFFFFFFF;
        for (int k = 1; k < 1000; k++) begin
            start = (k == 5 || k == 40);
            @(negedge clk);
            if (done === 1'b1) begin dc = cyc; ok = 1'b1; break; end
            if (busy !== 1'b1) gaps++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (!ok) begin bad++; $display("FAIL ignore_timeout: got no done want done"); end
        total++; if (dc - acc != LAT2) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", dc - acc, LAT2); end
        total++; if (gaps != 0) begin bad++; $display("FAIL ignore_busy_gap: got %0d gaps want 0", gaps); end
        total++; if (dones - d0 != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dones - d0); end
        total++; if (tgt !== 32'h12345678) begin bad++; $display("FAIL ignore_target: got %h want 12345678", tgt); end
    endtask

    task automatic test_abort;
        int acc, dc, d0;
        bit ok;
        d0 = dones;
        do_start(32'hA5A5A5A5, acc);
        repeat (49) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL abort_cs_n: got %b want 1", cs_n); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (sdo !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL abort_sdo_done: got sdo=%b done=%b want 0 0", sdo, done); end
`ifdef LUT_SERIAL_WRITER_TGT_RESET_EN
        total++; if (tgt_rst_n !== 1'b0) begin bad++; $display("FAIL abort_tgt_rst_n: got %b want 0", tgt_rst_n); end
`endif
        repeat (200) @(posedge clk);
        #1;
        total++; if (dones - d0 != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones - d0); end
        do_start(32'h0F1E2D3C, acc);
        wait_done(dc, ok);
        @(posedge clk); #1;
        total++; if (!ok || dc - acc != LAT2) begin bad++;
            $display("FAIL abort_reload_latency: got ok=%b lat=%0d want 1 %0d", ok, dc - acc, LAT2); end
        total++; if (tgt !== 32'h0F1E2D3C) begin bad++; $display("FAIL abort_reload_target: got %h want 0f1e2d3c", tgt); end
        total++; if (dones - d0 != 1) begin bad++; $display("FAIL abort_done_count: got %0d want 1", dones - d0); end
    endtask

    task automatic test_back_to_back;
        int acc, dc1, dc2, r0, d0;
        bit ok1, ok2;
        r0 = rises; d0 = dones;
        @(posedge clk); #1;
        start = 1'b1; table_in = 32'h13579BDF; acc = cyc;
        @(posedge clk); #1;
        table_in = 32'h2468ACE0;
        wait_done(dc1, ok1);
        total++; if (tgt !== 32'h13579BDF) begin bad++; $display("FAIL b2b_first_target: got %h want 13579bdf", tgt); end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        wait_done(dc2, ok2);
        @(posedge clk); #1;
        total++; if (!ok1 || !ok2) begin bad++; $display("FAIL b2b_timeout: got ok=%b%b want 11", ok1, ok2); end
        total++; if (dc1 - acc != LAT2) begin bad++; $display("FAIL b2b_latency1: got %0d want %0d", dc1 - acc, LAT2); end
        total++; if (dc2 - dc1 != LAT2) begin bad++; $display("FAIL b2b_latency2: got %0d want %0d", dc2 - dc1, LAT2); end
        total++; if (tgt !== 32'h2468ACE0) begin bad++; $display("FAIL b2b_second_target: got %h want 2468ace0", tgt); end
        total++; if (rises - r0 != 64) begin bad++; $display("FAIL b2b_rises: got %0d want 64", rises - r0); end
        total++; if (dones - d0 != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", dones - d0); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        table_in = '0; table_in1 = '0;
        test_reset();
        test_basic();
        test_clkdiv1();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
